somador_serial_ctrl: RTL and testbench

Sequencing controller that time-shares a single full-adder cell to add or subtract two WIDTH-bit operands bit-serially, LSB first, one bit per clock. It replaces a WIDTH-cell ripple chain where area matters more than latency. The block holds the operand shift registers, the carry flip-flop and the bit counter. It exposes a start/busy/done handshake to the requesting datapath.

---
 rtl/somador_serial_ctrl.sv | 135 +++++++++++++
 tb/tb_somador_serial_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/somador_serial_ctrl.sv
// somador_serial_ctrl
//   Bit-serial add/subtract sequencer. A single full-adder cell is reused
//   once per clock, LSB first, to process two WIDTH-bit operands. The block
//   holds the operand shift registers, the carry flop and the bit counter,
//   and offers a start/busy/done handshake.
//
//   Parameters:
//     WIDTH  operand/result width in bits (2..32)
//
//   Ports:
//     clk    system clock, rising edge
//     rst    synchronous active-high reset
//     start  request pulse, sampled only in IDLE
//     sub    0 = a+b, 1 = a-b, sampled with start
//     a, b   operands, sampled with start
//     busy   high while bits are being processed
//     done   one-cycle pulse when sum/cout are updated
//     sum    registered result, held until the next completion
//     cout   final carry out (for subtraction, 1 = no borrow)
//     ovf    signed overflow, present only when SOMADOR_SERIAL_OVF_EN is defined
//
//   Build option: define SOMADOR_SERIAL_OVF_EN to add the ovf output.

module somador_serial_ctrl #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SOMADOR_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_next;
  logic             last;

  // The shared full-adder cell
  always_comb begin
    s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
    c_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    last   = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SOMADOR_SERIAL_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction as a + ~b + 1: invert b and seed the carry with 1
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= {s_bit, r_sh[WIDTH-1:1]};
          carry <= c_next;
          if (last) begin
            // The final bit is merged directly so sum is complete at this edge
            sum   <= {s_bit, r_sh[WIDTH-1:1]};
            cout  <= c_next;
`ifdef SOMADOR_SERIAL_OVF_EN
            // carry currently holds the carry into the MSB
            ovf   <= carry ^ c_next;
`endif
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_somador_serial_ctrl.sv
// Testbench for somador_serial_ctrl (WIDTH=5). Expected results come from an
// integer model and are queued when an operation is issued, then popped and
// compared when done is observed.

module tb_somador_serial_ctrl;

  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SOMADOR_SERIAL_OVF_EN
  logic         ovf;
`endif

  somador_serial_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SOMADOR_SERIAL_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] prev_sum  = '0;
  logic         prev_cout = 1'b0;

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts);
    exp_t       e;
    logic [W:0] full;
    logic [W-1:0] bb;
    bb     = ts ? ~tb_ : tb_;
    full   = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, ts};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    if (ts) e.ovf = (ta[W-1] != tb_[W-1]) && (full[W-1] != ta[W-1]);
    else    e.ovf = (ta[W-1] == tb_[W-1]) && (full[W-1] != ta[W-1]);
    return e;
  endfunction

  // Issues one operation at a negedge and follows it to the cycle after done.
  // pulse_mask[k] re-asserts start (with a=11111) during RUN cycle k.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                        input logic [7:0] pulse_mask,
                        output int busy_n, output int done_n, output int lat, output int unstable);
    sb.push_back(model(ta, tb_, ts));
    a = ta; b = tb_; sub = ts; start = 1'b1;
    busy_n = 0; done_n = 0; lat = 0; unstable = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'($urandom);
      start = 1'b0;
      if (c < 8 && pulse_mask[c]) begin
        start = 1'b1;
        a     = '1;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        lat = c;
      end else if (done_n == 0 && (sum !== prev_sum || cout !== prev_cout)) begin
        unstable++;
      end
      if (done_n > 0 && !done) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %b expected 00000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
`ifdef SOMADOR_SERIAL_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    rst = 1'b0;
    @(negedge clk);
    prev_sum = '0; prev_cout = 1'b0;
  endtask

  // Runs a table of operations, checking result, handshake timing and hold behaviour
  task automatic test_ops(input string tag, input logic [W-1:0] ta[], input logic [W-1:0] tbv[],
                          input logic tsv[], input logic [7:0] mask);
    int   bn, dn, lt, un;
    exp_t e;
    for (int i = 0; i < ta.size(); i++) begin
      run_op(ta[i], tbv[i], tsv[i], mask, bn, dn, lt, un);
      e = sb.pop_front();
      checks++; if (sum !== e.sum) begin errors++; $display("FAIL %s_sum[%0d]: got %b expected %b", tag, i, sum, e.sum); end
      checks++; if (cout !== e.cout) begin errors++; $display("FAIL %s_cout[%0d]: got %b expected %b", tag, i, cout, e.cout); end
`ifdef SOMADOR_SERIAL_OVF_EN
      checks++; if (ovf !== e.ovf) begin errors++; $display("FAIL %s_ovf[%0d]: got %b expected %b", tag, i, ovf, e.ovf); end
`endif
      checks++; if (bn != W) begin errors++; $display("FAIL %s_busy_cycles[%0d]: got %0d expected %0d", tag, i, bn, W); end
      checks++; if (dn != 1) begin errors++; $display("FAIL %s_done_pulses[%0d]: got %0d expected 1", tag, i, dn); end
      checks++; if (lt != W + 1) begin errors++; $display("FAIL %s_latency[%0d]: got %0d expected %0d", tag, i, lt, W + 1); end
      checks++; if (un != 0) begin errors++; $display("FAIL %s_hold[%0d]: got %0d early changes expected 0", tag, i, un); end
      prev_sum = e.sum; prev_cout = e.cout;
    end
  endtask

  task automatic test_add;
    test_ops("add", '{5'b10000, 5'b11111, 5'b01010, 5'b00000},
                    '{5'b00001, 5'b00001, 5'b00101, 5'b00000},
                    '{1'b0, 1'b0, 1'b0, 1'b0}, 8'h00);
  endtask

  task automatic test_sub;
    test_ops("sub", '{5'b00011, 5'b00101, 5'b00000, 5'b10101},
                    '{5'b00101, 5'b00011, 5'b00000, 5'b10101},
                    '{1'b1, 1'b1, 1'b1, 1'b1}, 8'h00);
  endtask

  task automatic test_ignored_start;
    // start pulses on RUN cycles 2 and 4
    test_ops("ignored_start", '{5'b00001}, '{5'b00001}, '{1'b0}, 8'b0001_0100);
  endtask

  task automatic test_back_to_back;
    // each run_op returns in IDLE, so consecutive calls are one op per WIDTH+2 cycles
    test_ops("b2b", '{5'b01100, 5'b10011, 5'b11111, 5'b00111},
                    '{5'b00110, 5'b01001, 5'b11111, 5'b01000},
                    '{1'b0, 1'b1, 1'b0, 1'b1}, 8'h00);
  endtask

  task automatic test_ovf;
    test_ops("ovf", '{5'b01111, 5'b10000, 5'b11111}, '{5'b00001, 5'b00001, 5'b00001},
                    '{1'b0, 1'b1, 1'b0}, 8'h00);
  endtask

  task automatic test_reset_mid_run;
    int seen_done;
    a = 5'b01010; b = 5'b00101; sub = 1'b0; start = 1'b1;
    @(negedge clk);             // RUN cycle 1
    start = 1'b0;
    @(negedge clk);             // RUN cycle 2
    @(negedge clk);             // RUN cycle 3
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL midrst_sum: got %b expected 00000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout: got %b expected 0", cout); end
    seen_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", seen_done); end
    prev_sum = '0; prev_cout = 1'b0;
    test_ops("after_rst", '{5'b01010}, '{5'b00101}, '{1'b0}, 8'h00);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    test_ovf();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
